multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- FSM controller that sequences a shared-memory, single-ALU multicycle ARM datapath.
- Decodes Instr[31:12] and drives the datapath mux selects and write enables state by state.
- Holds the NZCV flag register and evaluates the condition field.
- Alternative to the single-cycle controller; used with the multicycle datapath top.

Parameters:
- STATE_W, 4, width of the state register and the state_o debug port.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- Instr  input  20  instruction bits [31:12] from the instruction register
- ALUFlags  input  4  {N,Z,C,V} from the ALU, current cycle
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0=PC, 1=ALU result register
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction register enable
- ResultSrc  output  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  output  1  ALU A select: 0=RD1, 1=PC
- ALUSrcB  output  2  ALU B select: 00=RD2, 01=ExtImm, 10=constant 4
- ALUControl  output  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- ImmSrc  output  2  equals Instr[27:26]
- RegSrc  output  2  [0]=(op==10), [1]=(op==01)
- RegWrite  output  1  register file write enable
- state_o  output  STATE_W  current state, for debug only

Behaviour:
- Field decode:
  - op=Instr[27:26]; I=Instr[25]; cmd=Instr[24:21]; S/L=Instr[20]; Rd=Instr[15:12]; cond=Instr[31:28].
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9.
  - Any other encoding goes to FETCH.
- Transitions:
  - FETCH->DECODE.
  - DECODE: op=00 -> EXECUTEI if I=1, else EXECUTER; op=01 -> MEMADR; op=10 -> BRANCH; op=11 -> FETCH (treated as NOP).
  - MEMADR: L=1 -> MEMREAD, else MEMWRITE.
  - MEMREAD->MEMWB.
  - EXECUTER/EXECUTEI->ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH -> FETCH.
- Latency: DP 4 cycles, LDR 5, STR 4, B 3, undefined op 2.
- Per-state outputs (any output not listed is 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ADD.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=RegW.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=cond_ex_q.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALU decode.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALU decode.
  - ALUWB: ResultSrc=00, RegWrite=RegW.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=cond_ex_q.
  - In MEMWB/ALUWB: RegW=cond_ex_q. If Rd==15, also PCWrite=cond_ex_q and RegWrite=0.
- ALU decode:
  - cmd 0100=ADD, 0010=SUB, 0000=AND, 1100=ORR.
  - Any other cmd -> ADD, and FlagW forced to 00.
- Flag update:
  - FlagW[1]=S (updates N,Z); FlagW[0]=S&(ADD|SUB) (updates C,V).
  - Flags are written at the end of EXECUTER/EXECUTEI only when cond_ex_q=1.
- Condition evaluation:
  - cond_ex is computed combinationally from cond and the flag register.
  - Codes: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE standard; 1110=always; 1111=never.
  - cond_ex_q latches cond_ex at the end of DECODE.
- Reset:
  - state=FETCH, flags=0000, cond_ex_q=0.
  - While reset=1, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - Reset asserted mid-instruction aborts it; no write enable fires in the reset cycle.

Optional Feature:
- Macro: MC_CTRL_MEM_WAIT_EN.
- When defined:
  - Adds input mem_ready (1 bit).
  - FETCH, MEMREAD and MEMWRITE hold their state until mem_ready=1.
  - IRWrite, PCWrite (in FETCH) and MemWrite assert only in the mem_ready=1 cycle; other outputs stay constant while waiting.
- When undefined:
  - No mem_ready port; memory is treated as always ready.

Test Plan:
- Reset for 2 cycles, then release -> state_o=0; IRWrite=1 and PCWrite=1 in the first cycle after release.
- ADDS R1,R2,R3 (0xE0921003), ALUFlags=0100 in EXECUTER -> states 0,1,6,8; ALUControl=00; RegWrite=1 in ALUWB; flags=0100.
- Then BEQ (cond 0000) -> states 0,1,9; PCWrite=1 in BRANCH. Repeat with flags=0000 -> PCWrite=0 in BRANCH.
- LDR R4,[R5,#8] (0xE5954008) -> states 0,1,2,3,4; AdrSrc=1 in MEMREAD; ResultSrc=01 and RegWrite=1 in MEMWB. STR (L=0) -> MemWrite=1 only in MEMWRITE.
- SUBNE with Z=1 -> full 4-state sequence runs; RegWrite=0, flags unchanged. Assert reset in EXECUTER -> next state FETCH, no write.
- With MEM_WAIT_EN, mem_ready=0 for 3 cycles in FETCH -> state holds, IRWrite=0; IRWrite=1 in the cycle mem_ready rises.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   FSM controller for a shared-memory, single-ALU multicycle ARM datapath.
//   Decodes Instr[31:12] (presented here as Instr[19:0]) and drives the
//   datapath selects and write enables one state at a time. It also holds
//   the NZCV flag register and evaluates the condition field.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   mem_ready   memory handshake (only when MC_CTRL_MEM_WAIT_EN is defined)
//   Instr       instruction bits [31:12] from the instruction register
//   ALUFlags    {N,Z,C,V} from the ALU in the current cycle
//   PCWrite     PC register enable
//   AdrSrc      memory address select: 0=PC, 1=ALU result register
//   MemWrite    data memory write enable
//   IRWrite     instruction register enable
//   ResultSrc   result mux: 00=ALUOut, 01=Data, 10=ALUResult
//   ALUSrcA     ALU A select: 0=RD1, 1=PC
//   ALUSrcB     ALU B select: 00=RD2, 01=ExtImm, 10=constant 4
//   ALUControl  00=ADD, 01=SUB, 10=AND, 11=ORR
//   ImmSrc      immediate extender select (Instr[27:26])
//   RegSrc      register-address selects: [0]=branch, [1]=memory
//   RegWrite    register file write enable
//   state_o     current state, debug only
//
// Optional feature
//   MC_CTRL_MEM_WAIT_EN: adds mem_ready. FETCH, MEMREAD and MEMWRITE wait
//   for mem_ready=1; IRWrite, PCWrite (FETCH) and MemWrite fire only in the
//   ready cycle. Without the macro memory is always ready.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
`ifdef MC_CTRL_MEM_WAIT_EN
  input  logic               mem_ready,
`endif
  input  logic [19:0]        Instr,
  input  logic [3:0]         ALUFlags,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUControl,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         RegSrc,
  output logic               RegWrite,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_MEMADR   = STATE_W'(2),
    S_MEMREAD  = STATE_W'(3),
    S_MEMWB    = STATE_W'(4),
    S_MEMWRITE = STATE_W'(5),
    S_EXECUTER = STATE_W'(6),
    S_EXECUTEI = STATE_W'(7),
    S_ALUWB    = STATE_W'(8),
    S_BRANCH   = STATE_W'(9)
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;     // {N,Z,C,V}
  logic       cond_ex_q, cond_ex_d;

  // Instruction fields (Instr[k] is instruction bit k+12)
  logic [1:0] op;
  logic       i_bit;
  logic [3:0] cmd;
  logic       s_bit;
  logic [3:0] rd;
  logic [3:0] cond;
  assign op    = Instr[15:14];
  assign i_bit = Instr[13];
  assign cmd   = Instr[12:9];
  assign s_bit = Instr[8];
  assign rd    = Instr[3:0];
  assign cond  = Instr[19:16];

  // Rn is consumed by the datapath, not by the controller.
  logic unused_rn;
  assign unused_rn = ^Instr[7:4];

  logic mem_rdy;
`ifdef MC_CTRL_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  // Condition evaluation against the stored flags
  logic flag_n, flag_z, flag_c, flag_v, cond_ex;
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~(flag_c & ~flag_z);
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // ALU decode; unsupported commands fall back to ADD and never touch flags
  logic [1:0] alu_dec;
  logic [1:0] flag_w;
  always_comb begin
    alu_dec = 2'b00;
    flag_w  = 2'b00;
    case (cmd)
      4'b0100: begin alu_dec = 2'b00; flag_w = {s_bit, s_bit}; end
      4'b0010: begin alu_dec = 2'b01; flag_w = {s_bit, s_bit}; end
      4'b0000: begin alu_dec = 2'b10; flag_w = {s_bit, 1'b0};  end
      4'b1100: begin alu_dec = 2'b11; flag_w = {s_bit, 1'b0};  end
      default: begin alu_dec = 2'b00; flag_w = 2'b00;          end
    endcase
  end

  // Next state and per-state outputs
  logic pc_write_c, mem_write_c, ir_write_c, reg_write_c;
  always_comb begin
    state_d     = S_FETCH;
    pc_write_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUControl  = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write_c = mem_rdy;
        pc_write_c = mem_rdy;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        state_d    = mem_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (op)
          2'b00:   state_d = i_bit ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = s_bit ? S_MEMREAD : S_MEMWRITE;  // bit 20 is L here
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        // A load into R15 redirects the PC instead of the register file
        if (rd == 4'hF) pc_write_c  = cond_ex_q;
        else            reg_write_c = cond_ex_q;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_c = cond_ex_q & mem_rdy;
        state_d     = mem_rdy ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        ALUControl = alu_dec;
        state_d    = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        if (rd == 4'hF) pc_write_c  = cond_ex_q;
        else            reg_write_c = cond_ex_q;
      end
      S_BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        pc_write_c = cond_ex_q;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Flags update at the end of an execute state, only if the instruction
  // actually executes.
  always_comb begin
    flags_d = flags_q;
    if (((state_q == S_EXECUTER) || (state_q == S_EXECUTEI)) && cond_ex_q) begin
      if (flag_w[1]) flags_d[3:2] = ALUFlags[3:2];
      if (flag_w[0]) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  // Condition result is frozen at the end of DECODE so later flag changes
  // cannot alter an instruction already in flight.
  assign cond_ex_d = (state_q == S_DECODE) ? cond_ex : cond_ex_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  // Write enables are gated by reset so an aborted instruction writes nothing
  assign PCWrite  = pc_write_c  & ~reset;
  assign IRWrite  = ir_write_c  & ~reset;
  assign MemWrite = mem_write_c & ~reset;
  assign RegWrite = reg_write_c & ~reset;

  assign ImmSrc  = op;
  assign RegSrc  = {(op == 2'b01), (op == 2'b10)};
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. Each call to cyc() covers one
// clock: inputs change on the falling edge, outputs are checked 1 ns later.
// Expected values: state, enables {PCWrite,IRWrite,MemWrite,RegWrite},
// datapath {AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUControl}, {ImmSrc,RegSrc}.
module tb_multicycle_controller;

  logic        clk;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0]  state_o;
`ifdef MC_CTRL_MEM_WAIT_EN
  logic        mem_ready;
  logic        mr_next;
`endif

  int n_tests;
  int n_fail;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef MC_CTRL_MEM_WAIT_EN
    .mem_ready  (mem_ready),
`endif
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .RegWrite   (RegWrite),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction bits [31:12]
  localparam logic [19:0] I_ADDS  = 20'hE0921;  // ADDS R1,R2,R3
  localparam logic [19:0] I_BEQ   = 20'h0A000;  // BEQ
  localparam logic [19:0] I_LDR   = 20'hE5954;  // LDR R4,[R5,#8]
  localparam logic [19:0] I_STR   = 20'hE5854;  // STR R4,[R5,#8]
  localparam logic [19:0] I_SUBNE = 20'h10521;  // SUBNES R1,R2,R3
  localparam logic [19:0] I_ADDI  = 20'hE2811;  // ADD R1,R1,#imm
  localparam logic [19:0] I_ADDPC = 20'hE080F;  // ADD PC,R0,R3
  localparam logic [19:0] I_UNDEF = 20'hEC000;  // op=11
  localparam logic [19:0] I_ORR   = 20'hE1821;  // ORR R1,R2,R3

  // Datapath vectors {AdrSrc,ResultSrc[1:0],ALUSrcA,ALUSrcB[1:0],ALUControl[1:0]}
  localparam logic [7:0] DP_FD   = 8'h58;  // FETCH / DECODE
  localparam logic [7:0] DP_MADR = 8'h04;  // MEMADR, EXECUTEI ADD
  localparam logic [7:0] DP_MRW  = 8'h80;  // MEMREAD / MEMWRITE
  localparam logic [7:0] DP_MWB  = 8'h20;
  localparam logic [7:0] DP_ADD  = 8'h00;  // EXECUTER ADD, ALUWB
  localparam logic [7:0] DP_SUB  = 8'h01;
  localparam logic [7:0] DP_ORR  = 8'h03;
  localparam logic [7:0] DP_BR   = 8'h44;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic rst, input logic [19:0] ins,
                     input logic [3:0] fl, input logic [3:0] st,
                     input logic [3:0] en, input logic [7:0] dp);
    logic [1:0] op;
    @(negedge clk);
    reset    = rst;
    Instr    = ins;
    ALUFlags = fl;
`ifdef MC_CTRL_MEM_WAIT_EN
    mem_ready = mr_next;
`endif
    #1;
    op = ins[15:14];
    check_eq({tag, " state"}, 32'(state_o), 32'(st));
    check_eq({tag, " wen"}, 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'(en));
    check_eq({tag, " dp"}, 32'({AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl}), 32'(dp));
    check_eq({tag, " imm/reg src"}, 32'({ImmSrc, RegSrc}),
             32'({op, (op == 2'b01), (op == 2'b10)}));
    $display("[TB] %-10s rst=%0d state=%0d wen=%b", tag, rst, state_o,
             {PCWrite, IRWrite, MemWrite, RegWrite});
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b1;
    Instr    = 20'h0;
    ALUFlags = 4'h0;
`ifdef MC_CTRL_MEM_WAIT_EN
    mem_ready = 1'b1;
    mr_next   = 1'b1;
`endif

    // Reset held two cycles: FETCH, enables forced low
    cyc("rst0", 1, 20'h0, 4'h0, 4'd0, 4'b0000, DP_FD);
    cyc("rst1", 1, 20'h0, 4'h0, 4'd0, 4'b0000, DP_FD);

    // ADDS, Z=1 from ALU -> flags 0100
    cyc("adds.f", 0, I_ADDS, 4'b0100, 4'd0, 4'b1100, DP_FD);
    cyc("adds.d", 0, I_ADDS, 4'b0100, 4'd1, 4'b0000, DP_FD);
    cyc("adds.e", 0, I_ADDS, 4'b0100, 4'd6, 4'b0000, DP_ADD);
    cyc("adds.w", 0, I_ADDS, 4'b0100, 4'd8, 4'b0001, DP_ADD);
    // BEQ taken
    cyc("beq1.f", 0, I_BEQ, 4'h0, 4'd0, 4'b1100, DP_FD);
    cyc("beq1.d", 0, I_BEQ, 4'h0, 4'd1, 4'b0000, DP_FD);
    cyc("beq1.b", 0, I_BEQ, 4'h0, 4'd9, 4'b1000, DP_BR);
    // ADDS clearing flags, then BEQ not taken
    cyc("adds2.f", 0, I_ADDS, 4'b0000, 4'd0, 4'b1100, DP_FD);
    cyc("adds2.d", 0, I_ADDS, 4'b0000, 4'd1, 4'b0000, DP_FD);
    cyc("adds2.e", 0, I_ADDS, 4'b0000, 4'd6, 4'b0000, DP_ADD);
    cyc("adds2.w", 0, I_ADDS, 4'b0000, 4'd8, 4'b0001, DP_ADD);
    cyc("beq2.f", 0, I_BEQ, 4'h0, 4'd0, 4'b1100, DP_FD);
    cyc("beq2.d", 0, I_BEQ, 4'h0, 4'd1, 4'b0000, DP_FD);
    cyc("beq2.b", 0, I_BEQ, 4'h0, 4'd9, 4'b0000, DP_BR);
    // LDR: 5 states
    cyc("ldr.f", 0, I_LDR, 4'h0, 4'd0, 4'b1100, DP_FD);
    cyc("ldr.d", 0, I_LDR, 4'h0, 4'd1, 4'b0000, DP_FD);
    cyc("ldr.a", 0, I_LDR, 4'h0, 4'd2, 4'b0000, DP_MADR);
    cyc("ldr.r", 0, I_LDR, 4'h0, 4'd3, 4'b0000, DP_MRW);
    cyc("ldr.w", 0, I_LDR, 4'h0, 4'd4, 4'b0001, DP_MWB);
    // STR: MemWrite only in MEMWRITE
    cyc("str.f", 0, I_STR, 4'h0, 4'd0, 4'b1100, DP_FD);
    cyc("str.d", 0, I_STR, 4'h0, 4'd1, 4'b0000, DP_FD);
    cyc("str.a", 0, I_STR, 4'h0, 4'd2, 4'b0000, DP_MADR);
    cyc("str.m", 0, I_STR, 4'h0, 4'd5, 4'b0010, DP_MRW);
    // Set Z again, then SUBNES must not write nor update flags
    cyc("adds3.f", 0, I_ADDS, 4'b0100, 4'd0, 4'b1100, DP_FD);
    cyc("adds3.d", 0, I_ADDS, 4'b0100, 4'd1, 4'b0000, DP_FD);
    cyc("adds3.e", 0, I_ADDS, 4'b0100, 4'd6, 4'b0000, DP_ADD);
    cyc("adds3.w", 0, I_ADDS, 4'b0100, 4'd8, 4'b0001, DP_ADD);
    cyc("subne.f", 0, I_SUBNE, 4'b0000, 4'd0, 4'b1100, DP_FD);
    cyc("subne.d", 0, I_SUBNE, 4'b0000, 4'd1, 4'b0000, DP_FD);
    cyc("subne.e", 0, I_SUBNE, 4'b0000, 4'd6, 4'b0000, DP_SUB);
    cyc("subne.w", 0, I_SUBNE, 4'b0000, 4'd8, 4'b0000, DP_ADD);
    // Z still set -> BEQ taken
    cyc("beq3.f", 0, I_BEQ, 4'h0, 4'd0, 4'b1100, DP_FD);
    cyc("beq3.d", 0, I_BEQ, 4'h0, 4'd1, 4'b0000, DP_FD);
    cyc("beq3.b", 0, I_BEQ, 4'h0, 4'd9, 4'b1000, DP_BR);
    // Immediate ADD through EXECUTEI
    cyc("addi.f", 0, I_ADDI, 4'h0, 4'd0, 4'b1100, DP_FD);
    cyc("addi.d", 0, I_ADDI, 4'h0, 4'd1, 4'b0000, DP_FD);
    cyc("addi.e", 0, I_ADDI, 4'h0, 4'd7, 4'b0000, DP_MADR);
    cyc("addi.w", 0, I_ADDI, 4'h0, 4'd8, 4'b0001, DP_ADD);
    // Rd=15: writeback goes to PC, not the register file
    cyc("addpc.f", 0, I_ADDPC, 4'h0, 4'd0, 4'b1100, DP_FD);
    cyc("addpc.d", 0, I_ADDPC, 4'h0, 4'd1, 4'b0000, DP_FD);
    cyc("addpc.e", 0, I_ADDPC, 4'h0, 4'd6, 4'b0000, DP_ADD);
    cyc("addpc.w", 0, I_ADDPC, 4'h0, 4'd8, 4'b1000, DP_ADD);
    // Undefined op: 2 cycles
    cyc("undef.f", 0, I_UNDEF, 4'h0, 4'd0, 4'b1100, DP_FD);
    cyc("undef.d", 0, I_UNDEF, 4'h0, 4'd1, 4'b0000, DP_FD);
    // ORR aborted by reset in EXECUTER
    cyc("orr.f", 0, I_ORR, 4'h0, 4'd0, 4'b1100, DP_FD);
    cyc("orr.d", 0, I_ORR, 4'h0, 4'd1, 4'b0000, DP_FD);
    cyc("orr.e", 1, I_ORR, 4'h0, 4'd6, 4'b0000, DP_ORR);
    cyc("orr.rst", 1, I_ORR, 4'h0, 4'd0, 4'b0000, DP_FD);
    // ADDS aborted by reset in ALUWB: no RegWrite, flags cleared by reset
    cyc("adds4.f", 0, I_ADDS, 4'b0100, 4'd0, 4'b1100, DP_FD);
    cyc("adds4.d", 0, I_ADDS, 4'b0100, 4'd1, 4'b0000, DP_FD);
    cyc("adds4.e", 0, I_ADDS, 4'b0100, 4'd6, 4'b0000, DP_ADD);
    cyc("adds4.w", 1, I_ADDS, 4'b0100, 4'd8, 4'b0000, DP_ADD);
    cyc("adds4.rst", 1, I_BEQ, 4'h0, 4'd0, 4'b0000, DP_FD);
    cyc("beq4.f", 0, I_BEQ, 4'h0, 4'd0, 4'b1100, DP_FD);
    cyc("beq4.d", 0, I_BEQ, 4'h0, 4'd1, 4'b0000, DP_FD);
    cyc("beq4.b", 0, I_BEQ, 4'h0, 4'd9, 4'b0000, DP_BR);

`ifdef MC_CTRL_MEM_WAIT_EN
    // FETCH holds while memory is not ready
    mr_next = 1'b0;
    cyc("wait0", 0, I_UNDEF, 4'h0, 4'd0, 4'b0000, DP_FD);
    cyc("wait1", 0, I_UNDEF, 4'h0, 4'd0, 4'b0000, DP_FD);
    cyc("wait2", 0, I_UNDEF, 4'h0, 4'd0, 4'b0000, DP_FD);
    mr_next = 1'b1;
    cyc("wait.rdy", 0, I_UNDEF, 4'h0, 4'd0, 4'b1100, DP_FD);
    cyc("wait.d", 0, I_UNDEF, 4'h0, 4'd1, 4'b0000, DP_FD);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
